// File: rtl/spu_sm_ctrl_v2.sv
// spu_sm_ctrl_v2: softmax row sequencer (max, exp-sum, reciprocal, normalise) driving gbuf and a lane block
module spu_sm_ctrl_v2 #(
  parameter int ADDR_WIDTH   = 12,
  parameter int LANES        = 4,
  parameter int LANE_WIDTH   = 8,
  parameter int RLATENCY     = 1,
  parameter int PROC_LATENCY = 0
) (
  input  logic                        core_clk,
  input  logic                        rst_n,
  input  logic                        sm_start,
  output logic                        sm_busy,
  output logic                        sm_end,
  input  logic                        sm_skip_max,
  input  logic [ADDR_WIDTH-1:0]       spu_matrix_y,
  input  logic [ADDR_WIDTH-1:0]       spu_matrix_x,
  input  logic [ADDR_WIDTH-1:0]       im_base_addr,
  input  logic [ADDR_WIDTH-1:0]       om_base_addr,
  input  logic [ADDR_WIDTH-1:0]       ifm_addr_align,
  input  logic [ADDR_WIDTH-1:0]       ofm_addr_align,
  output logic                        sm_gbuf_ren,
  output logic [ADDR_WIDTH-1:0]       sm_gbuf_raddr,
  input  logic [LANES*LANE_WIDTH-1:0] sm_gbuf_rdata,
  output logic                        sm_gbuf_wen,
  output logic [ADDR_WIDTH-1:0]       sm_gbuf_waddr,
  output logic [LANES*LANE_WIDTH-1:0] sm_gbuf_wdata,
  output logic [LANES-1:0]            sm_gbuf_wmask,
  output logic [2:0]                  blk_phase,
  output logic                        blk_valid_in,
  output logic                        blk_row_first,
  output logic [LANES-1:0]            blk_lane_mask,
  output logic [LANES*LANE_WIDTH-1:0] blk_data_in,
  output logic                        blk_reci_start,
  input  logic                        blk_reci_done,
  input  logic [LANES*LANE_WIDTH-1:0] blk_data_out
);
  localparam int LB = $clog2(LANES);
  localparam int D  = RLATENCY + PROC_LATENCY;
  localparam int CW = ADDR_WIDTH + 5;
  typedef enum logic [2:0] {IDLE = 3'd0, MAX = 3'd1, SUM = 3'd2, RECI = 3'd3, NORM = 3'd4} state_t;
  state_t state, nxt;
  logic [ADDR_WIDTH-1:0] x, y, row_cnt, row_in_base, row_out_base, ifm_align, ofm_align, wk, rem;
  logic [CW-1:0] cnt, words;
  logic [LANES-1:0] last_mask, word_mask;
  logic [LANES-1:0] m_sr [D];
  logic [D-1:0] v_sr;
  logic [RLATENCY-1:0] f_sr;
  logic skip, zero_end, pass, ren, pass_end, last_row, accept, zero_dim;
  assign rem       = x & ADDR_WIDTH'(LANES - 1);
  assign words     = CW'(x >> LB) + CW'(rem != '0);
  for (genvar i = 0; i < LANES; i++) begin : g_mask
    assign last_mask[i] = (rem == '0) || (ADDR_WIDTH'(i) < rem);
  end
  assign word_mask = (cnt == words - CW'(1)) ? last_mask : '1;
  assign pass      = state == MAX || state == SUM || state == NORM;
  assign ren       = pass && cnt < words;
  // each pass lasts long enough for the last word to clear both the read and lane-block latencies
  assign pass_end  = pass && cnt == words + CW'(D - 1);
  assign last_row  = row_cnt == y - ADDR_WIDTH'(1);
  assign zero_dim  = spu_matrix_x == '0 || spu_matrix_y == '0;
  assign accept    = state == IDLE && sm_start && !zero_end;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (accept && !zero_dim) ? (sm_skip_max ? SUM : MAX) : IDLE;
      MAX:     nxt = pass_end ? SUM : MAX;
      SUM:     nxt = pass_end ? RECI : SUM;
      RECI:    nxt = blk_reci_done ? NORM : RECI;
      NORM:    nxt = pass_end ? (last_row ? IDLE : (skip ? SUM : MAX)) : NORM;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge core_clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      skip <= 1'b0;
      ifm_align <= '0;
      ofm_align <= '0;
      row_in_base <= '0;
      row_out_base <= '0;
      row_cnt <= '0;
      zero_end <= 1'b0;
      cnt <= '0;
      wk <= '0;
      v_sr <= '0;
      f_sr <= '0;
      for (int i = 0; i < D; i++) m_sr[i] <= '0;
    end else begin
      zero_end <= accept && zero_dim;
      cnt <= (state != nxt || state == IDLE) ? '0 : cnt + CW'(cnt != '1);
      wk <= (state != nxt) ? '0 : wk + ADDR_WIDTH'(sm_gbuf_wen);
      v_sr <= D'({v_sr, ren});
      f_sr <= RLATENCY'({f_sr, ren && cnt == '0});
      m_sr[0] <= ren ? word_mask : '0;
      for (int i = 1; i < D; i++) m_sr[i] <= m_sr[i-1];
      if (accept) begin
        x <= spu_matrix_x;
        y <= spu_matrix_y;
        skip <= sm_skip_max;
        ifm_align <= ifm_addr_align;
        ofm_align <= ofm_addr_align;
        row_in_base <= im_base_addr;
        row_out_base <= om_base_addr;
        row_cnt <= '0;
      end else if (state == NORM && pass_end) begin
        row_cnt <= row_cnt + ADDR_WIDTH'(1);
        row_in_base <= row_in_base + ifm_align;
        row_out_base <= row_out_base + ofm_align;
      end
    end
  end
  assign sm_busy        = state != IDLE;
  assign sm_end         = zero_end || (state == NORM && pass_end && last_row);
  assign sm_gbuf_ren    = ren;
  assign sm_gbuf_raddr  = ren ? row_in_base + cnt[ADDR_WIDTH-1:0] : '0;
  assign sm_gbuf_wen    = state == NORM && v_sr[D-1];
  assign sm_gbuf_waddr  = sm_gbuf_wen ? row_out_base + wk : '0;
  assign sm_gbuf_wmask  = sm_gbuf_wen ? m_sr[D-1] : '0;
  assign sm_gbuf_wdata  = blk_data_out;
  assign blk_phase      = state;
  assign blk_valid_in   = v_sr[RLATENCY-1];
  assign blk_row_first  = f_sr[RLATENCY-1];
  assign blk_lane_mask  = m_sr[RLATENCY-1];
  assign blk_data_in    = sm_gbuf_rdata;
  assign blk_reci_start = state == RECI && cnt == '0;
endmodule

// File: tb/tb_spu_sm_ctrl_v2.sv
// tb_spu_sm_ctrl_v2: directed checks of the softmax sequencer at two latency configurations
module tb_spu_sm_ctrl_v2;
  localparam int AW = 12, L = 4, LW = 8, DW = L * LW;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic st0 = 0, st1 = 0, skp = 0, done = 0, sel = 0;
  logic [AW-1:0] x_in = 0, y_in = 0, ib = 0, ob = 0, ia = 0, oa = 0;
  logic [DW-1:0] rd = 0, dout;
  assign dout = ~rd;
  logic busy0, end0, ren0, wen0, vin0, rf0, rs0, busy1, end1, ren1, wen1, vin1, rf1, rs1;
  logic [AW-1:0] raddr0, waddr0, raddr1, waddr1;
  logic [DW-1:0] wdata0, din0, wdata1, din1;
  logic [L-1:0] wmask0, lmask0, wmask1, lmask1;
  logic [2:0] ph0, ph1;
  logic m_busy, m_end, m_ren, m_wen, m_vin, m_rf, m_rs;
  logic [AW-1:0] m_raddr, m_waddr;
  logic [DW-1:0] m_wdata, m_din;
  logic [L-1:0] m_wmask, m_lmask;
  logic [2:0] m_phase;
  assign {m_busy, m_end, m_ren, m_wen, m_vin, m_rf, m_rs} = sel ? {busy1, end1, ren1, wen1, vin1, rf1, rs1}
                                                                : {busy0, end0, ren0, wen0, vin0, rf0, rs0};
  assign m_raddr = sel ? raddr1 : raddr0;
  assign m_waddr = sel ? waddr1 : waddr0;
  assign m_wdata = sel ? wdata1 : wdata0;
  assign m_din   = sel ? din1 : din0;
  assign m_wmask = sel ? wmask1 : wmask0;
  assign m_lmask = sel ? lmask1 : lmask0;
  assign m_phase = sel ? ph1 : ph0;

  spu_sm_ctrl_v2 #(.ADDR_WIDTH(AW), .LANES(L), .LANE_WIDTH(LW), .RLATENCY(1), .PROC_LATENCY(0)) u0 (
    .core_clk(clk), .rst_n(rst_n), .sm_start(st0), .sm_busy(busy0), .sm_end(end0), .sm_skip_max(skp),
    .spu_matrix_y(y_in), .spu_matrix_x(x_in), .im_base_addr(ib), .om_base_addr(ob),
    .ifm_addr_align(ia), .ofm_addr_align(oa), .sm_gbuf_ren(ren0), .sm_gbuf_raddr(raddr0),
    .sm_gbuf_rdata(rd), .sm_gbuf_wen(wen0), .sm_gbuf_waddr(waddr0), .sm_gbuf_wdata(wdata0),
    .sm_gbuf_wmask(wmask0), .blk_phase(ph0), .blk_valid_in(vin0), .blk_row_first(rf0),
    .blk_lane_mask(lmask0), .blk_data_in(din0), .blk_reci_start(rs0), .blk_reci_done(done),
    .blk_data_out(dout));
  spu_sm_ctrl_v2 #(.ADDR_WIDTH(AW), .LANES(L), .LANE_WIDTH(LW), .RLATENCY(3), .PROC_LATENCY(2)) u1 (
    .core_clk(clk), .rst_n(rst_n), .sm_start(st1), .sm_busy(busy1), .sm_end(end1), .sm_skip_max(skp),
    .spu_matrix_y(y_in), .spu_matrix_x(x_in), .im_base_addr(ib), .om_base_addr(ob),
    .ifm_addr_align(ia), .ofm_addr_align(oa), .sm_gbuf_ren(ren1), .sm_gbuf_raddr(raddr1),
    .sm_gbuf_rdata(rd), .sm_gbuf_wen(wen1), .sm_gbuf_waddr(waddr1), .sm_gbuf_wdata(wdata1),
    .sm_gbuf_wmask(wmask1), .blk_phase(ph1), .blk_valid_in(vin1), .blk_row_first(rf1),
    .blk_lane_mask(lmask1), .blk_data_in(din1), .blk_reci_start(rs1), .blk_reci_done(done),
    .blk_data_out(dout));

  int errors = 0, checks = 0;
  int rc = 0;
  // reciprocal block model: done is sampled high in the third RECI cycle
  initial forever begin
    @(negedge clk);
    rc = (m_phase == 3'd3) ? rc + 1 : 0;
    done = rc >= 3;
  end
  initial forever begin
    @(posedge clk);
    #1 rd = $urandom;
  end

  logic [AW-1:0] ra[$], wa[$];
  logic [L-1:0] wm[$], lm[$];
  logic [63:0] phseq;
  int nph, nrf, nrs, nbusy, nend, end_c, fnr, fwn, nnorm, nmax, nbad_d;
  logic busy_after;

  task automatic run(input logic s, input int inj, input int budget);
    logic [2:0] last;
    logic [AW-1:0] xs;
    bit fin;
    ra.delete(); wa.delete(); wm.delete(); lm.delete();
    phseq = 0; nph = 0; nrf = 0; nrs = 0; nbusy = 0; nend = 0; end_c = -1;
    fnr = -1; fwn = -1; nnorm = 0; nmax = 0; nbad_d = 0; busy_after = 1'bx;
    xs = x_in; sel = s; last = 3'd0; fin = 0;
    @(negedge clk); st0 = !s; st1 = s;
    @(negedge clk); st0 = 0; st1 = 0;
    for (int c = 0; c < budget; c++) begin
      if (m_phase !== last) begin phseq = {phseq[60:0], m_phase}; nph++; last = m_phase; end
      if (fin) begin busy_after = m_busy; checks++; return; end
      if (m_ren) begin ra.push_back(m_raddr); if (m_phase == 3'd4 && fnr < 0) fnr = c; end
      if (m_wen) begin wa.push_back(m_waddr); wm.push_back(m_wmask); if (fwn < 0) fwn = c; end
      if (m_vin) lm.push_back(m_lmask);
      if (m_din !== rd || m_wdata !== dout) nbad_d++;
      nrf += int'(m_rf); nrs += int'(m_rs); nbusy += int'(m_busy);
      nnorm += int'(m_phase == 3'd4); nmax += int'(m_phase == 3'd1);
      if (m_end) begin nend++; if (end_c < 0) end_c = c; fin = 1; end
      if (c == inj) begin st0 = !s; st1 = s; x_in = 12'd4; end
      if (c == inj + 1) begin st0 = 0; st1 = 0; x_in = xs; end
      @(negedge clk);
    end
    errors++; checks++;
    $display("FAIL run_timeout: no sm_end within %0d cycles", budget);
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy0, end0, ren0, wen0, vin0, rf0, rs0, raddr0, waddr0, wmask0, lmask0, ph0} !== '0) begin
      errors++; $display("FAIL reset_u0: outputs=%h want 0", {busy0, end0, ren0, wen0, vin0, rf0, rs0, raddr0, waddr0, wmask0, lmask0, ph0});
    end
    checks++;
    if ({busy1, end1, ren1, wen1, vin1, rf1, rs1, raddr1, waddr1, wmask1, lmask1, ph1} !== '0) begin
      errors++; $display("FAIL reset_u1: outputs=%h want 0", {busy1, end1, ren1, wen1, vin1, rf1, rs1, raddr1, waddr1, wmask1, lmask1, ph1});
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy0, ph0, busy1, ph1} !== '0) begin
      errors++; $display("FAIL reset_idle: busy/phase=%h want 0", {busy0, ph0, busy1, ph1});
    end
  endtask

  task automatic test_full_rows;
    int nb;
    x_in = 12'd16; y_in = 12'd2; ib = 12'h100; ob = 12'h200; ia = 12'd8; oa = 12'd8; skp = 0;
    run(0, -1, 200);
    nb = 0;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 3; p++)
        for (int k = 0; k < 4; k++)
          if (ra.size() == 24 && ra[r*12+p*4+k] !== 12'(12'h100 + 8*r + k)) nb++;
    checks++; if (ra.size() != 24) begin errors++; $display("FAIL full_read_count: got %0d want 24", ra.size()); end
    checks++; if (nb != 0) begin errors++; $display("FAIL full_read_addr: mismatches=%0d want 0", nb); end
    nb = 0;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++)
        if (wa.size() == 8 && (wa[r*4+k] !== 12'(12'h200 + 8*r + k) || wm[r*4+k] !== 4'hF)) nb++;
    checks++; if (wa.size() != 8) begin errors++; $display("FAIL full_write_count: got %0d want 8", wa.size()); end
    checks++; if (nb != 0) begin errors++; $display("FAIL full_write_addr_mask: mismatches=%0d want 0", nb); end
    checks++; if (nend != 1 || end_c != 35) begin errors++; $display("FAIL full_end: count=%0d cycle=%0d want 1/35", nend, end_c); end
    checks++; if (phseq !== 64'o123412340 || nph != 9) begin errors++; $display("FAIL full_phases: got %o want 123412340", phseq); end
    checks++; if (nrs != 2 || nrf != 6) begin errors++; $display("FAIL full_reci_first: reci=%0d first=%0d want 2/6", nrs, nrf); end
    checks++; if (nbusy != 36 || busy_after !== 1'b0) begin errors++; $display("FAIL full_busy: cycles=%0d after=%b want 36/0", nbusy, busy_after); end
    checks++; if (nbad_d != 0) begin errors++; $display("FAIL full_data_pass: bad=%0d want 0", nbad_d); end
  endtask

  task automatic test_ragged;
    int nb;
    logic [L-1:0] em;
    x_in = 12'd10; y_in = 12'd1; ib = 12'h010; ob = 12'h020; ia = 0; oa = 0; skp = 0;
    run(0, -1, 200);
    nb = 0;
    for (int i = 0; i < 9; i++) begin
      em = (i % 3 == 2) ? 4'b0011 : 4'hF;
      if (lm.size() == 9 && lm[i] !== em) nb++;
    end
    checks++; if (lm.size() != 9 || nb != 0) begin errors++; $display("FAIL ragged_lane_mask: n=%0d bad=%0d want 9/0", lm.size(), nb); end
    checks++;
    if (wm.size() != 3 || wm[0] !== 4'hF || wm[1] !== 4'hF || wm[2] !== 4'b0011) begin
      errors++; $display("FAIL ragged_wmask: n=%0d last=%b want 3/0011", wm.size(), wm.size() == 3 ? wm[2] : 4'bx);
    end
    checks++;
    if (wa.size() != 3 || wa[0] !== 12'h020 || wa[2] !== 12'h022 || ra.size() != 9 || ra[8] !== 12'h012) begin
      errors++; $display("FAIL ragged_addr: writes=%0d reads=%0d want 3/9", wa.size(), ra.size());
    end
  endtask

  task automatic test_skip_max;
    x_in = 12'd8; y_in = 12'd1; ib = 12'h040; ob = 12'h050; skp = 1;
    run(0, -1, 200);
    skp = 0;
    checks++; if (phseq !== 64'o2340 || nph != 4) begin errors++; $display("FAIL skip_phases: got %o want 2340", phseq); end
    checks++; if (ra.size() != 4) begin errors++; $display("FAIL skip_reads: got %0d want 4", ra.size()); end
    checks++; if (nend != 1 || end_c != 8 || wa.size() != 2) begin errors++; $display("FAIL skip_end: end=%0d cycle=%0d writes=%0d want 1/8/2", nend, end_c, wa.size()); end
  endtask

  task automatic test_zero_dim;
    for (int t = 0; t < 2; t++) begin
      x_in = t == 0 ? 12'd0 : 12'd5;
      y_in = t == 0 ? 12'd3 : 12'd0;
      run(0, -1, 20);
      checks++; if (end_c != 0 || nend != 1) begin errors++; $display("FAIL zero_end_%0d: cycle=%0d count=%0d want 0/1", t, end_c, nend); end
      checks++; if (ra.size() != 0 || wa.size() != 0) begin errors++; $display("FAIL zero_access_%0d: reads=%0d writes=%0d want 0/0", t, ra.size(), wa.size()); end
      checks++; if (nbusy != 0 || busy_after !== 1'b0) begin errors++; $display("FAIL zero_busy_%0d: cycles=%0d want 0", t, nbusy); end
    end
  endtask

  task automatic test_latency;
    x_in = 12'd8; y_in = 12'd1; ib = 12'h300; ob = 12'h400; skp = 0;
    run(1, 3, 200);
    checks++; if (fwn - fnr != 5) begin errors++; $display("FAIL lat_wen_delay: got %0d want 5", fwn - fnr); end
    checks++; if (nnorm != 7 || nmax != 7) begin errors++; $display("FAIL lat_pass_len: norm=%0d max=%0d want 7/7", nnorm, nmax); end
    checks++; if (ra.size() != 6 || wa.size() != 2) begin errors++; $display("FAIL lat_counts: reads=%0d writes=%0d want 6/2", ra.size(), wa.size()); end
    checks++;
    if (wa.size() == 2 && (wa[0] !== 12'h400 || wa[1] !== 12'h401)) begin
      errors++; $display("FAIL lat_waddr: got %h,%h want 400,401", wa[0], wa[1]);
    end
    checks++; if (nend != 1 || end_c != 23) begin errors++; $display("FAIL lat_end: count=%0d cycle=%0d want 1/23", nend, end_c); end
    sel = 0;
  endtask

  task automatic test_reset_mid;
    int n;
    bit hit;
    x_in = 12'd16; y_in = 12'd2; ib = 12'h100; ob = 12'h200; ia = 12'd8; oa = 12'd8; skp = 0; sel = 0;
    @(negedge clk); st0 = 1;
    @(negedge clk); st0 = 0;
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (ph0 == 3'd4) hit = 1;
      @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL rmid_reach_norm: NORM not reached want reached"); end
    rst_n = 0;
    #1;
    checks++;
    if ({busy0, end0, ren0, wen0, vin0, wmask0, lmask0, ph0} !== '0) begin
      errors++; $display("FAIL rmid_outputs: got %h want 0", {busy0, end0, ren0, wen0, vin0, wmask0, lmask0, ph0});
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    n = 0;
    repeat (15) begin
      @(negedge clk);
      n += int'(wen0) + int'(end0) + int'(ren0) + int'(busy0) + int'(vin0);
    end
    checks++; if (n != 0) begin errors++; $display("FAIL rmid_quiet: activity=%0d want 0", n); end
    run(0, -1, 200);
    checks++;
    if (ra.size() != 24 || wa.size() != 8 || nend != 1 || end_c != 35) begin
      errors++; $display("FAIL rmid_rerun: reads=%0d writes=%0d end=%0d cycle=%0d want 24/8/1/35", ra.size(), wa.size(), nend, end_c);
    end
  endtask

  initial begin
    test_reset;
    test_full_rows;
    test_ragged;
    test_skip_max;
    test_zero_dim;
    test_latency;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spu_sm_ctrl_v2.md
Name: spu_sm_ctrl_v2

Overview:
- Second-generation softmax sequencer for the SPU: row-wise max, exp-sum, reciprocal and normalise passes over a gbuf-resident matrix.
- Generalised to LANES elements per gbuf word.
- Exposes a parametrised lane-block control interface so the arithmetic datapath lives in a separate per-lane block.
- New over the previous generation: ragged row lengths with a last-word lane mask, an optional skip-max mode, configurable datapath latency, a busy flag, and zero-dimension handling.

Parameters:
ADDR_WIDTH, 12, gbuf address and dimension width
LANES, 4, elements per gbuf word (power of two, 1..16)
LANE_WIDTH, 8, bits per element
RLATENCY, 1, gbuf ren-to-rdata cycles (1..4)
PROC_LATENCY, 0, lane-block rdata-to-data_out cycles (0..7)

Ports:
core_clk  in  1  process clock
rst_n  in  1  asynchronous active-low reset
sm_start  in  1  start pulse; ignored while sm_busy
sm_busy  out  1  high from the cycle after an accepted start until the sm_end cycle, inclusive
sm_end  out  1  one-cycle completion pulse
sm_skip_max  in  1  1: skip the MAX pass (input is pre-biased); latched at start
spu_matrix_y  in  ADDR_WIDTH  rows; latched at start
spu_matrix_x  in  ADDR_WIDTH  elements per row; latched at start
im_base_addr  in  ADDR_WIDTH  input base word address; latched at start
om_base_addr  in  ADDR_WIDTH  output base word address; latched at start
ifm_addr_align  in  ADDR_WIDTH  input row stride in words; latched at start
ofm_addr_align  in  ADDR_WIDTH  output row stride in words; latched at start
sm_gbuf_ren  out  1  gbuf read enable
sm_gbuf_raddr  out  ADDR_WIDTH  read address
sm_gbuf_rdata  in  LANES*LANE_WIDTH  read data, RLATENCY cycles after ren
sm_gbuf_wen  out  1  write enable
sm_gbuf_waddr  out  ADDR_WIDTH  write address
sm_gbuf_wdata  out  LANES*LANE_WIDTH  write data (equals blk_data_out)
sm_gbuf_wmask  out  LANES  per-lane write mask
blk_phase  out  3  current state encoding
blk_valid_in  out  1  sm_gbuf_rdata is valid for the lane block this cycle
blk_row_first  out  1  qualifies the first valid word of a pass
blk_lane_mask  out  LANES  valid lanes of the current valid word
blk_data_in  out  LANES*LANE_WIDTH  sm_gbuf_rdata passthrough
blk_reci_start  out  1  one-cycle pulse requesting the reciprocal
blk_reci_done  in  1  reciprocal finished
blk_data_out  in  LANES*LANE_WIDTH  normalised data, PROC_LATENCY cycles after blk_valid_in

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- States and encoding: IDLE=0, MAX=1, SUM=2, RECI=3, NORM=4. blk_phase equals the state.
- Word count per row: W = ceil(x/LANES).
  - Last-word mask: lanes 0..((x-1) mod LANES) set.
  - All other words: all-ones mask.
- Start handling:
  - Start accepted in IDLE: latch the config; go to MAX, or to SUM when sm_skip_max=1.
  - If x==0 or y==0: stay IDLE and pulse sm_end in the next cycle. No reads are issued.
- Read passes (MAX, SUM, NORM), with the pass entered at cycle T:
  - sm_gbuf_ren is high for cycles T..T+W-1 with no gaps.
  - sm_gbuf_raddr = row_in_base + k, for k = 0..W-1.
  - blk_valid_in and blk_lane_mask are the ren and mask values delayed by RLATENCY through a shift register.
  - blk_row_first marks k==0.
  - Pass length is W+RLATENCY+PROC_LATENCY cycles; the next state is entered at cycle T+W+RLATENCY+PROC_LATENCY.
- MAX -> SUM.
- SUM -> RECI.
- RECI:
  - blk_reci_start pulses in the first RECI cycle only.
  - The block waits indefinitely for blk_reci_done.
  - It enters NORM in the cycle after done is sampled high.
  - blk_reci_done outside RECI is ignored.
- NORM writes:
  - sm_gbuf_wen = blk_valid_in delayed PROC_LATENCY, NORM only.
  - sm_gbuf_waddr = row_out_base + k, where k is the write-word counter.
  - sm_gbuf_wmask = lane mask delayed by the same amount.
- NORM end:
  - Row counter increments.
  - row_in_base += ifm_addr_align; row_out_base += ofm_addr_align. Addresses wrap modulo 2^ADDR_WIDTH.
  - If rows done < y: go to MAX (or SUM when skip_max). Otherwise go to IDLE, with sm_end asserted in that same transition cycle.
- sm_busy falls in the cycle after sm_end.
- A new start is accepted in the cycle after sm_end at the earliest.
- Reset mid-operation: immediate return to IDLE. The delay pipelines are flushed, and no wen or sm_end is emitted after reset release.
- sm_start while busy has no effect on state or latched config.

Test Plan:
- LANES=4, x=16, y=2, bases 0x100/0x200, aligns 8/8, RLATENCY=1, PROC_LATENCY=0, reci_done 3 cycles after start -> per row, three 4-cycle ren bursts at 0x100..0x103 (row 2: 0x108..0x10B); writes at 0x200..0x203 then 0x208..0x20B, wmask=4'hF; exactly one sm_end; 8 wen total.
- x=10, y=1, LANES=4 -> W=3; last word wmask and blk_lane_mask = 4'b0011; first two words 4'hF.
- sm_skip_max=1, x=8, y=1 -> no MAX phase; blk_phase sequence 2,3,4,0; two read bursts only.
- x=0 or y=0 -> sm_end one cycle after start; ren and wen never asserted; sm_busy stays 0.
- RLATENCY=3, PROC_LATENCY=2, x=8 -> NORM wen first asserted 5 cycles after the first NORM ren; pass length 7 cycles; start pulsed mid-run ignored.
- rst_n low during NORM, then released -> all outputs 0; no wen; fresh start runs a correct full sequence.
